// File: rtl/rvvi_retire_arbiter.sv
// Per-hart retire-event FIFOs merged round-robin onto one ready/valid stream,
// with sticky overflow / order-gap flags and a saturating drop counter.
module rvvi_retire_arbiter #(
    parameter int NHART = 2,
    parameter int XLEN  = 32,
    parameter int ILEN  = 32,
    parameter int DEPTH = 4,
    localparam int HW   = (NHART > 1) ? $clog2(NHART) : 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [NHART-1:0]      in_valid,
    input  logic [64*NHART-1:0]   in_order,
    input  logic [XLEN*NHART-1:0] in_pc,
    input  logic [ILEN*NHART-1:0] in_insn,
    input  logic [NHART-1:0]      in_trap,
    input  logic [2*NHART-1:0]    in_mode,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [HW-1:0]         out_hart,
    output logic [63:0]           out_order,
    output logic [XLEN-1:0]       out_pc,
    output logic [ILEN-1:0]       out_insn,
    output logic                  out_trap,
    output logic [1:0]            out_mode,
    output logic [NHART-1:0]      overflow,
    output logic [NHART-1:0]      order_err,
    output logic [15:0]           drop_cnt,
    input  logic                  clr_err
);

    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        logic [63:0]     order;
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] insn;
        logic            trap;
        logic [1:0]      mode;
    } entry_t;

    // Handshake: an event transfers on a clk edge where out_valid && out_ready;
    // out_valid and all out_* fields come straight from flops and hold while stalled.

    entry_t          mem_q [NHART][DEPTH];
    entry_t          mem_d [NHART][DEPTH];
    logic [AW-1:0]   wr_ptr_q [NHART];
    logic [AW-1:0]   wr_ptr_d [NHART];
    logic [AW-1:0]   rd_ptr_q [NHART];
    logic [AW-1:0]   rd_ptr_d [NHART];
    logic [AW:0]     cnt_q [NHART];
    logic [AW:0]     cnt_d [NHART];
    logic [63:0]     last_order_q [NHART];
    logic [63:0]     last_order_d [NHART];
    logic [NHART-1:0] seen_q, seen_d;
    logic [NHART-1:0] overflow_q, overflow_d;
    logic [NHART-1:0] order_err_q, order_err_d;
    logic [15:0]     drop_cnt_q, drop_cnt_d;
    logic [HW-1:0]   rr_ptr_q, rr_ptr_d;
    logic            out_valid_q, out_valid_d;
    logic [HW-1:0]   out_hart_q, out_hart_d;
    entry_t          out_q, out_d;

    logic            load_en;
    logic            found;
    logic [HW-1:0]   gnt;
    int              idx;
    logic [NHART-1:0] pop, push, drop, full;
    logic [3:0]      n_drop;
    logic [15:0]     drop_base;
    logic [16:0]     drop_sum;
    entry_t          wr_ev;

    always_comb begin
        mem_d        = mem_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        cnt_d        = cnt_q;
        last_order_d = last_order_q;
        seen_d       = seen_q;
        rr_ptr_d     = rr_ptr_q;
        out_valid_d  = out_valid_q;
        out_hart_d   = out_hart_q;
        out_d        = out_q;
        overflow_d   = clr_err ? '0 : overflow_q;
        order_err_d  = clr_err ? '0 : order_err_q;
        drop_base    = clr_err ? '0 : drop_cnt_q;
        load_en      = !out_valid_q || out_ready;
        found        = 1'b0;
        gnt          = '0;
        idx          = 0;
        pop          = '0;
        push         = '0;
        drop         = '0;
        full         = '0;
        n_drop       = '0;
        wr_ev        = '0;

        // Cyclic search for the first non-empty FIFO starting at rr_ptr.
        for (int i = 0; i < NHART; i++) begin
            idx = int'(rr_ptr_q) + i;
            if (idx >= NHART) idx = idx - NHART;
            if (!found && cnt_q[idx] != '0) begin
                found = 1'b1;
                gnt   = HW'(idx);
            end
        end

        if (load_en) begin
            if (found) begin
                out_valid_d = 1'b1;
                out_hart_d  = gnt;
                out_d       = mem_q[gnt][rd_ptr_q[gnt]];
                rr_ptr_d    = (gnt == HW'(NHART - 1)) ? '0 : gnt + 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end

        for (int h = 0; h < NHART; h++) begin
            pop[h]  = load_en && found && (gnt == HW'(h));
            full[h] = (cnt_q[h] == (AW + 1)'(DEPTH));
            push[h] = in_valid[h] && (!full[h] || pop[h]);
            drop[h] = in_valid[h] && full[h] && !pop[h];

            wr_ev.order = in_order[64*h +: 64];
            wr_ev.pc    = in_pc[XLEN*h +: XLEN];
            wr_ev.insn  = in_insn[ILEN*h +: ILEN];
            wr_ev.trap  = in_trap[h];
            wr_ev.mode  = in_mode[2*h +: 2];

            if (push[h]) begin
                mem_d[h][wr_ptr_q[h]] = wr_ev;
                wr_ptr_d[h]           = wr_ptr_q[h] + 1'b1;
            end
            if (pop[h]) rd_ptr_d[h] = rd_ptr_q[h] + 1'b1;
            if (push[h] && !pop[h]) cnt_d[h] = cnt_q[h] + 1'b1;
            if (!push[h] && pop[h]) cnt_d[h] = cnt_q[h] - 1'b1;

            // Order check applies to dropped events too, so a drop never masks a gap.
            if (in_valid[h]) begin
                if (seen_q[h] && wr_ev.order != last_order_q[h] + 64'd1) order_err_d[h] = 1'b1;
                last_order_d[h] = wr_ev.order;
                seen_d[h]       = 1'b1;
            end
            if (drop[h]) overflow_d[h] = 1'b1;
            n_drop = n_drop + {3'b000, drop[h]};
        end

        drop_sum   = {1'b0, drop_base} + {13'd0, n_drop};
        drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int h = 0; h < NHART; h++) begin
                for (int d = 0; d < DEPTH; d++) mem_q[h][d] <= '0;
                wr_ptr_q[h]     <= '0;
                rd_ptr_q[h]     <= '0;
                cnt_q[h]        <= '0;
                last_order_q[h] <= '0;
            end
            seen_q      <= '0;
            overflow_q  <= '0;
            order_err_q <= '0;
            drop_cnt_q  <= '0;
            rr_ptr_q    <= '0;
            out_valid_q <= 1'b0;
            out_hart_q  <= '0;
            out_q       <= '0;
        end else begin
            mem_q        <= mem_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            cnt_q        <= cnt_d;
            last_order_q <= last_order_d;
            seen_q       <= seen_d;
            overflow_q   <= overflow_d;
            order_err_q  <= order_err_d;
            drop_cnt_q   <= drop_cnt_d;
            rr_ptr_q     <= rr_ptr_d;
            out_valid_q  <= out_valid_d;
            out_hart_q   <= out_hart_d;
            out_q        <= out_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_hart  = out_hart_q;
    assign out_order = out_q.order;
    assign out_pc    = out_q.pc;
    assign out_insn  = out_q.insn;
    assign out_trap  = out_q.trap;
    assign out_mode  = out_q.mode;
    assign overflow  = overflow_q;
    assign order_err = order_err_q;
    assign drop_cnt  = drop_cnt_q;

endmodule

// File: doc/rvvi_retire_arbiter.md
# rvvi_retire_arbiter

Collects per-hart retire events from the RVVI trace bus (valid, order, pc_rdata, insn, trap, mode) and serializes them into one ready/valid stream for the functional-coverage collector. Each hart has a small FIFO, a round-robin arbiter shares the single output port, and the block flags dropped events and order-count gaps. It sits between the rvviTrace interface (retire slot 0 of each hart) and the coverage sampler.

## Interface
- NHART, 2: number of harts; 1..8
- XLEN, 32: pc width
- ILEN, 32: insn width
- DEPTH, 4: per-hart FIFO entries; power of two, 2..16
- clk  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- in_valid  in  NHART  retire event valid, bit h = hart h
- in_order  in  64*NHART  order count, hart h at [64h+63:64h]
- in_pc  in  XLEN*NHART  pc_rdata per hart
- in_insn  in  ILEN*NHART  instruction per hart
- in_trap  in  NHART  trap flag per hart
- in_mode  in  2*NHART  privilege mode per hart
- out_valid  out  1  output event valid
- out_ready  in  1  consumer accepts
- out_hart  out  $clog2(NHART) (min 1)  source hart id
- out_order / out_pc / out_insn / out_trap / out_mode  out  64/XLEN/ILEN/1/2  event fields
- overflow  out  NHART  sticky: hart h lost an event
- order_err  out  NHART  sticky: hart h order gap
- drop_cnt  out  16  total dropped events, saturating
- clr_err  in  1  synchronous clear of overflow, order_err, drop_cnt

## Operation
- Push: in_valid[h] at a clk edge writes hart h fields into FIFO h unless FIFO h full and not popped that same edge (push+pop at full both succeed, count unchanged).
- Drop: in_valid[h] with FIFO h full and no pop -> event discarded, overflow[h] <= 1, drop_cnt += 1 (holds at 16'hFFFF). Several harts dropping same edge add their count.
- Order check: per-hart last_order register and seen bit (0 at reset). On every in_valid[h] (accepted or dropped): if seen and in_order != last_order+1 (64-bit wrap) -> order_err[h] <= 1; then last_order <= in_order, seen <= 1.
- Output register: load enabled when out_valid==0 or out_ready==1. When enabled and any FIFO non-empty, grant the first non-empty hart at or after rr_ptr (cyclic), pop its head into output register, out_valid <= 1, rr_ptr <= grant+1 mod NHART. Enabled with all FIFOs empty -> out_valid <= 0.
- While out_valid && !out_ready, all out_* fields hold stable.
- clr_err: clears sticky flags and drop_cnt that edge; a new drop/gap on the same edge wins (flag set, drop_cnt = number of drops that edge).
- Reset (any time, mid-transfer included): FIFOs empty, rr_ptr=0, seen=0, last_order=0; out_valid=0, out_hart=0, all out_* fields 0, overflow=0, order_err=0, drop_cnt=0. In-flight events are discarded.

## Timing
- Latency: event pushed at edge E into an empty system with out_ready=1 -> out_valid high after edge E+1; no combinational path from in_* to out_*.
- Throughput: one event per cycle sustained on output; each hart may push every cycle.
- out_ready is sampled only at edges; out_valid never depends combinationally on out_ready.
- Flags and drop_cnt update at the same edge as the causing in_valid.

## Test plan
- Single event: hart0 order=5, pc=0x80000000, insn=0x00000013 -> after 1 edge out_valid=1, out_hart=0, fields match; out_ready=1 next edge -> out_valid=0.
- Round-robin fairness: NHART=2, both harts push every cycle for 8 cycles, out_ready=1 -> out_hart sequence 0,1,0,1,...; each hart's orders appear in push order; no drops while DEPTH not exceeded.
- Backpressure/overflow: out_ready=0, hart1 pushes DEPTH+2 events (DEPTH=4) -> first event held on output, 4 queued, 1 dropped: overflow=2'b10, drop_cnt=1; releasing out_ready yields 5 events in order.
- Order gap: hart0 orders 10,11,13 -> order_err[0]=1 after third push; clr_err -> 0; then 14 -> stays 0; order 0xFFFF_FFFF_FFFF_FFFF then 0 -> no error.
- Push+pop at full: FIFO0 full, out_ready=1, in_valid[0]=1 -> no drop, count stays DEPTH.
- Reset mid-operation: assert reset_n=0 with 3 queued events and out_valid=1 -> out_valid=0, flags/drop_cnt 0 immediately; after release first push has no order check.
